// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-path constants
// Purpose: default address width, instruction width and NOP encoding shared
// by the fetch-path blocks.
package core_pkg;
  localparam int          CORE_ADDRESS_BITS = 12;
  localparam int          INSTR_BITS        = 32;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
endpackage

// File: rtl/fetch_addr_fifo.sv
// rtl/fetch_addr_fifo.sv - circular buffer of outstanding fetch addresses
// Purpose: DEPTH x WIDTH in-order address queue with explicit occupancy count.
// Ports:
//   clock, reset      core clock, synchronous active-low reset
//   push, push_data   write push_data at tail
//   pop               retire head entry
//   clear             empty the queue (priority over push and pop)
//   head_data         oldest address (valid when count != 0)
//   count             number of entries held
module fetch_addr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;

  assign head_data = mem[head];

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem[tail] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_BITS'(1);
      if (pop)  head <= head + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_BITS'(1);
        2'b01:   count <= count - CNT_BITS'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_req_tracker.sv
// rtl/fetch_req_tracker.sv - in-order fetch request tracker between IF and I-cache
// Purpose: queues issued fetch addresses, pairs each I-cache response with the
// oldest live address, forwards matched (PC, instruction) to decode one cycle
// later, silently drops responses of flushed requests, and flags protocol errors.
// Ports:
//   clock, reset                 core clock, synchronous active-low reset
//   req_valid/req_addr/req_ready fetch request from IF
//   rsp_valid/rsp_addr/rsp_data  instruction returned by the I-cache
//   flush                        redirect: squash all outstanding requests
//   out_valid/out_pc/out_instruction  matched pair to decode (1-cycle pulse)
//   occupancy                    live outstanding entries
//   err_overflow/err_spurious/err_mismatch  sticky protocol error flags
module fetch_req_tracker
  import core_pkg::*;
#(
  parameter int ADDRESS_BITS = CORE_ADDRESS_BITS,
  parameter int DEPTH        = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [ADDRESS_BITS-1:0]   req_addr,
  output logic                      req_ready,
  input  logic                      rsp_valid,
  input  logic [ADDRESS_BITS-1:0]   rsp_addr,
  input  logic [INSTR_BITS-1:0]     rsp_data,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [ADDRESS_BITS-1:0]   out_pc,
  output logic [INSTR_BITS-1:0]     out_instruction,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      err_overflow,
  output logic                      err_spurious,
  output logic                      err_mismatch
);
  localparam int CNT_BITS = $clog2(DEPTH) + 1;

  logic [CNT_BITS-1:0]     drop_cnt;
  logic [CNT_BITS:0]       total;
  logic [ADDRESS_BITS-1:0] head_addr;
  logic                    push;
  logic                    rsp_drop;
  logic                    rsp_spurious;
  logic                    rsp_match;
  logic                    rsp_mismatch;
  logic                    consumed;

  // Flushed-but-unanswered requests still occupy I-cache slots, so they
  // count against capacity until their responses drain.
  assign total     = {1'b0, occupancy} + {1'b0, drop_cnt};
  assign req_ready = (total < (CNT_BITS+1)'(DEPTH)) && !flush;
  assign push      = req_valid && req_ready;

  assign rsp_drop     = rsp_valid && (drop_cnt != '0);
  assign rsp_spurious = rsp_valid && (drop_cnt == '0) && (occupancy == '0);
  assign rsp_match    = rsp_valid && (drop_cnt == '0) && (occupancy != '0) &&
                        (rsp_addr == head_addr);
  assign rsp_mismatch = rsp_valid && (drop_cnt == '0) && (occupancy != '0) &&
                        (rsp_addr != head_addr);
  assign consumed     = rsp_drop || rsp_match;

  fetch_addr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDRESS_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (req_addr),
    .pop       (rsp_match),
    .clear     (flush),
    .head_data (head_addr),
    .count     (occupancy)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      drop_cnt        <= '0;
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_instruction <= '0;
      err_overflow    <= 1'b0;
      err_spurious    <= 1'b0;
      err_mismatch    <= 1'b0;
    end else begin
      // On flush every live entry becomes a pending drop, less the one
      // response (if any) already retired this cycle.
      if (flush) begin
        drop_cnt <= drop_cnt + occupancy - CNT_BITS'(consumed);
      end else if (rsp_drop) begin
        drop_cnt <= drop_cnt - CNT_BITS'(1);
      end

      out_valid <= rsp_match && !flush;
      if (rsp_match && !flush) begin
        out_pc          <= head_addr;
        out_instruction <= rsp_data;
      end

      if (req_valid && !req_ready && !flush) err_overflow <= 1'b1;
      if (rsp_spurious)                       err_spurious <= 1'b1;
      if (rsp_mismatch)                       err_mismatch <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_req_tracker.sv
// tb/tb_fetch_req_tracker.sv - scoreboard testbench for fetch_req_tracker
module tb_fetch_req_tracker;
  localparam int AW    = 12;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic [AW-1:0] rsp_addr;
  logic [31:0]   rsp_data;
  logic          flush;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [31:0]   out_instruction;
  logic [1:0]    occupancy;
  logic          err_overflow;
  logic          err_spurious;
  logic          err_mismatch;

  always #5 clock = ~clock;

  fetch_req_tracker #(.ADDRESS_BITS(AW), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_addr        (rsp_addr),
    .rsp_data        (rsp_data),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .occupancy       (occupancy),
    .err_overflow    (err_overflow),
    .err_spurious    (err_spurious),
    .err_mismatch    (err_mismatch)
  );

  // Reference model: outstanding live addresses, count of flushed responses
  // still owed by the cache, and sticky error bits.
  logic [AW-1:0]    m_q[$];
  int               m_drop;
  logic             m_ovf, m_spur, m_mism;
  logic [AW+31:0]   exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected pair.
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {52'd0, out_pc}, 64'hFFFF_FFFF);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("out_pc", 64'(out_pc), 64'(e[AW+31:32]));
        chk("out_instruction", 64'(out_instruction), 64'(e[31:0]));
      end
    end
  end

  task automatic model_clear();
    m_q.delete();
    m_drop = 0;
    m_ovf = 0; m_spur = 0; m_mism = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    req_valid = 0; req_addr = '0; rsp_valid = 0; rsp_addr = '0; rsp_data = '0; flush = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
    end
    model_clear();
    exp_q.delete();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instruction", 64'(out_instruction), 64'd0);
    chk("rst_errs", {61'd0, err_overflow, err_spurious, err_mismatch}, 64'd0);
    reset = 1'b1;
  endtask

  // One cycle: drive inputs, check combinational outputs against the model,
  // advance the model by the response/flush rules, clock, check sticky flags.
  task automatic step(input logic rv, input logic [AW-1:0] ra,
                      input logic sv, input logic [AW-1:0] sa,
                      input logic [31:0] sd, input logic fl);
    bit ready, matched;
    logic [AW-1:0] pc;
    req_valid = rv; req_addr = ra; rsp_valid = sv; rsp_addr = sa; rsp_data = sd; flush = fl;
    #1;
    ready = (m_q.size() + m_drop < DEPTH) && !fl;
    chk("req_ready", 64'(req_ready), 64'(ready));
    chk("occupancy", 64'(occupancy), 64'(m_q.size()));
    if (rv && !ready && !fl) m_ovf = 1;
    matched = 0;
    if (sv) begin
      if (m_drop > 0) m_drop--;
      else if (m_q.size() == 0) m_spur = 1;
      else if (sa == m_q[0]) begin
        pc = m_q.pop_front();
        matched = 1;
        if (!fl) exp_q.push_back({pc, sd});
      end else m_mism = 1;
    end
    if (fl) begin
      m_drop += m_q.size();
      m_q.delete();
    end else if (rv && ready) begin
      m_q.push_back(ra);
    end
    @(posedge clock); #1;
    chk("err_flags", {61'd0, err_overflow, err_spurious, err_mismatch},
        {61'd0, m_ovf, m_spur, m_mism});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    model_clear();
    do_reset(2);
    idle(1);

    // Basic in-order delivery
    step(1, 12'h000, 0, '0, '0, 0);
    step(1, 12'h004, 0, '0, '0, 0);
    idle(1);
    step(0, '0, 1, 12'h000, 32'h0050_0093, 0);
    step(0, '0, 1, 12'h004, 32'h0010_0113, 0);
    idle(2);

    // Overflow with two outstanding
    step(1, 12'h000, 0, '0, '0, 0);
    step(1, 12'h004, 0, '0, '0, 0);
    step(1, 12'h008, 0, '0, '0, 0);
    chk("overflow_sticky", 64'(err_overflow), 64'd1);
    step(0, '0, 1, 12'h000, 32'h1111_1111, 0);
    step(0, '0, 1, 12'h004, 32'h2222_2222, 0);
    idle(2);

    // Flush: both responses dropped, then new request delivered
    step(1, 12'h010, 0, '0, '0, 0);
    step(1, 12'h014, 0, '0, '0, 0);
    step(1, 12'h018, 0, '0, '0, 1);
    step(1, 12'h01C, 0, '0, '0, 0);
    step(0, '0, 1, 12'h010, 32'hDEAD_0010, 0);
    step(0, '0, 1, 12'h014, 32'hDEAD_0014, 0);
    step(1, 12'h0B0, 0, '0, '0, 0);
    step(0, '0, 1, 12'h0B0, 32'h0000_0013, 0);
    idle(2);

    // Mismatch, then spurious after reset
    step(1, 12'h020, 0, '0, '0, 0);
    step(0, '0, 1, 12'h024, 32'h3333_3333, 0);
    chk("mismatch_sticky", 64'(err_mismatch), 64'd1);
    step(0, '0, 1, 12'h020, 32'h4444_4444, 0);
    do_reset(1);
    step(0, '0, 1, 12'h000, 32'h5555_5555, 0);
    chk("spurious_sticky", 64'(err_spurious), 64'd1);

    // Back-to-back wrap: push and pop in the same cycle
    do_reset(1);
    step(1, 12'h000, 0, '0, '0, 0);
    for (int i = 1; i < 10; i++)
      step(1, 12'(4 * i), 1, 12'(4 * (i - 1)), 32'hA000_0000 + 32'(i - 1), 0);
    step(0, '0, 1, 12'h024, 32'hA000_0009, 0);
    idle(2);

    // Reset mid-operation with two outstanding
    step(1, 12'h040, 0, '0, '0, 0);
    step(1, 12'h044, 0, '0, '0, 0);
    do_reset(1);
    step(0, '0, 1, 12'h040, 32'h6666_6666, 0);
    idle(2);

    // Randomized traffic
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      logic rv, sv, fl;
      logic [AW-1:0] ra, sa;
      if ($urandom_range(0, 79) == 0) begin
        do_reset(1);
        continue;
      end
      rv = ($urandom_range(0, 1) == 1);
      ra = 12'($urandom) & 12'hFFC;
      sv = ($urandom_range(0, 9) < 6);
      sa = 12'($urandom) & 12'hFFC;
      if (m_drop == 0 && m_q.size() != 0 && $urandom_range(0, 99) < 85) sa = m_q[0];
      fl = ($urandom_range(0, 11) == 0);
      step(rv, ra, sv, sa, $urandom, fl);
    end
    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_req_tracker.md
Name: fetch_req_tracker

Overview:
Sits between the IF stage and the L1 instruction cache interface. Records each fetch address issued to the I-cache in an in-order outstanding-request queue. Matches each returned instruction against the oldest outstanding address and hands matched (PC, instruction) pairs to the decode pipe. Discards responses belonging to flushed requests, and raises sticky error flags on protocol violations such as overflow, spurious responses and address mismatch.

Parameters:
ADDRESS_BITS, 12, width of fetch/PC addresses
DEPTH, 2, maximum outstanding requests; power of two, >= 2
CNT_BITS, $clog2(DEPTH)+1, width of occupancy/drop counters (derived, not overridable)

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-low reset (reset==0 resets on rising clock edge)
req_valid  input  1  IF issues fetch request this cycle
req_addr  input  ADDRESS_BITS  fetch address (PC_reg)
req_ready  output  1  tracker can accept a request this cycle
rsp_valid  input  1  I-cache returns an instruction
rsp_addr  input  ADDRESS_BITS  address the response belongs to
rsp_data  input  32  instruction word
flush  input  1  branch/jump redirect; squash all outstanding requests
out_valid  output  1  matched instruction valid to decode
out_pc  output  ADDRESS_BITS  PC of matched instruction
out_instruction  output  32  matched instruction
occupancy  output  CNT_BITS  live (unflushed) outstanding entries
err_overflow  output  1  sticky: req_valid while req_ready==0
err_spurious  output  1  sticky: rsp_valid with nothing outstanding
err_mismatch  output  1  sticky: rsp_addr != oldest live address

Behaviour:
- Reset (reset==0 at posedge): queue empty, drop_cnt=0, all outputs 0, all errors cleared. Reset mid-operation discards every in-flight entry with no output.
- Outstanding total = occupancy + drop_cnt. req_ready = (total < DEPTH) & ~flush. Combinational from registered state and flush.
- Push: req_valid & req_ready -> req_addr written at tail, tail wraps modulo DEPTH.
- req_valid & ~req_ready & ~flush -> request dropped, err_overflow set.
- Response handling, in priority order each cycle:
  1. drop_cnt>0: the response is discarded without comparison, and drop_cnt decrements.
  2. Else if occupancy==0: err_spurious set, response discarded.
  3. Else if rsp_addr==head address: pop the head. Next cycle out_valid=1, out_pc=head address, out_instruction=rsp_data.
  4. Else: err_mismatch set. The response is discarded and the head is not popped.
- Output latency: exactly 1 cycle after a matching rsp_valid. out_valid is a single-cycle pulse per match. out_pc/out_instruction hold their last value when out_valid=0.
- Flush: at the clock edge, drop_cnt <= drop_cnt + occupancy − (1 if a response was consumed by rules 1 or 3 this cycle), and the queue is emptied (head=tail, occupancy=0).
  - A response matched in the flush cycle still produces out_valid=0: it is suppressed.
  - A request in the flush cycle is not accepted, and err_overflow is not set.
- Simultaneous push and pop in a non-flush cycle: both take effect and occupancy is unchanged. Full-queue push+pop is not possible because req_ready is 0 when full.
- Wrap-around: head/tail pointers are $clog2(DEPTH) bits. Occupancy is tracked explicitly, so full versus empty is unambiguous.
- Error flags clear only on reset.

Decomposition:
- Shared package (core_pkg): default ADDRESS_BITS, instruction width constant (32), NOP encoding 32'h00000013.
- One sub-module: fetch_addr_fifo (DEPTH x ADDRESS_BITS circular buffer).
  - Ports: push, pop, clear, head_data, count.
  - Clear has priority over push and pop.
- Matching, drop counter, error logic and output register live in the top.

Test Plan:
1. Reset held low 2 cycles, then released -> all outputs 0, req_ready=1, occupancy=0.
2. Basic order: push 0x000 and 0x004 on consecutive cycles, so occupancy=2 and req_ready=0. Respond 0x000/0x00500093 then 0x004/0x00100113 -> out_valid pulses 1 cycle after each response, with matching out_pc/out_instruction. Occupancy returns to 0.
3. Overflow: with 2 outstanding, drive req_valid=1 addr 0x008 -> not queued, err_overflow=1 sticky, occupancy stays 2.
4. Flush: push 0x010, 0x014, then pulse flush -> drop_cnt=2 and req_ready=0 until both responses arrive. The responses for 0x010 and 0x014 produce no out_valid. A new request 0x0B0 is then accepted and its response is delivered.
5. Mismatch and spurious cases:
   - Push 0x020, respond with addr 0x024 -> err_mismatch=1, no out_valid, occupancy=1.
   - On empty queue after reset, rsp_valid with addr 0x000 -> err_spurious=1.
6. Wrap and reset mid-operation:
   - Issue 10 request/response pairs 0x000..0x024 back-to-back (push and pop in the same cycle) -> 10 in-order outputs, no errors.
   - Assert reset with 2 outstanding -> queue empty, no out_valid afterward.
